// File: rtl/mem_wb_stage.sv
// mem_wb_stage: memory-access stage of a five-stage RISC-V pipeline.
// Performs word loads/stores against an internal RAM with a fixed
// multi-cycle latency and drives the MEM/WB pipeline register.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no access pending; a non-memory op passes straight through
// BUSY  | access in flight; r_cnt counts the cycles already spent

module mem_wb_stage #(
    parameter int DEPTH_WORDS = 256,
    parameter int ADDR_W      = 8,
    parameter int MEM_LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  Mem_In_Rd,
    input  logic [31:0] Mem_In_Aluresult,
    input  logic [31:0] Mem_In_ReadData2,
    input  logic        Mem_In_Reg_Write,
    input  logic [1:0]  Mem_In_Output_Select,
    input  logic        Mem_In_MemWrite,
    input  logic        Mem_In_MemRead,
    output logic        Mem_Stall,
    output logic [4:0]  Wb_Out_Rd,
    output logic [31:0] Wb_Out_Aluresult,
    output logic [31:0] Wb_Out_ReadData,
    output logic        Wb_Out_Reg_Write,
    output logic [1:0]  Wb_Out_Output_Select
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam logic [2:0] LAST_CNT = 3'(MEM_LATENCY - 1);

    state_t            r_state;
    state_t            w_state_next;
    logic [2:0]        r_cnt;
    logic [2:0]        w_cnt_next;
    logic              w_access;
    logic              w_is_load;
    logic              w_complete;
    logic              w_stall;
    logic [ADDR_W-1:0] w_idx;
    logic [31:0]       r_mem [DEPTH_WORDS];

    // Upper address bits and byte offset are dropped: addresses wrap and
    // misaligned accesses hit the containing word.
    assign w_idx     = Mem_In_Aluresult[ADDR_W+1:2];
    assign w_access  = Mem_In_MemRead | Mem_In_MemWrite;
    // A simultaneous read+write is a store, so it never returns load data.
    assign w_is_load = Mem_In_MemRead & ~Mem_In_MemWrite;
    assign Mem_Stall = w_stall;

    // State and access-cycle counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= 3'd0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // Next state, stall and completion decode.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_stall      = 1'b0;
        w_complete   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_access) begin
                    if (MEM_LATENCY == 1) begin
                        w_complete = 1'b1;
                    end else begin
                        w_stall      = 1'b1;
                        w_state_next = BUSY;
                        w_cnt_next   = 3'd1;
                    end
                end
            end
            BUSY: begin
                if (r_cnt == LAST_CNT) begin
                    w_complete   = 1'b1;
                    w_state_next = IDLE;
                    w_cnt_next   = 3'd0;
                end else begin
                    w_stall    = 1'b1;
                    w_cnt_next = r_cnt + 3'd1;
                end
            end
            default: begin
                w_state_next = IDLE;
                w_cnt_next   = 3'd0;
            end
        endcase
        if (reset) begin
            w_stall    = 1'b0;
            w_complete = 1'b0;
        end
    end

    // MEM/WB pipeline register: bubble while stalled, inputs otherwise.
    always_ff @(posedge clk) begin
        if (reset || w_stall) begin
            Wb_Out_Rd            <= 5'd0;
            Wb_Out_Aluresult     <= 32'd0;
            Wb_Out_ReadData      <= 32'd0;
            Wb_Out_Reg_Write     <= 1'b0;
            Wb_Out_Output_Select <= 2'd0;
        end else begin
            Wb_Out_Rd            <= Mem_In_Rd;
            Wb_Out_Aluresult     <= Mem_In_Aluresult;
            Wb_Out_ReadData      <= (w_complete && w_is_load) ? r_mem[w_idx] : 32'd0;
            Wb_Out_Reg_Write     <= Mem_In_Reg_Write;
            Wb_Out_Output_Select <= Mem_In_Output_Select;
        end
    end

    // Data RAM write; only the completion edge of a store writes, and
    // w_complete is already suppressed under reset.
    always_ff @(posedge clk) begin
        if (w_complete && Mem_In_MemWrite) begin
            r_mem[w_idx] <= Mem_In_ReadData2;
        end
    end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Testbench for mem_wb_stage: transaction-level model plus per-cycle compare
// and a few literal expectations on directed vectors.

module tb_mem_wb_stage;

    localparam int LAT    = 3;
    localparam int DEPTH  = 256;
    localparam int ADDR_W = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [4:0]  in_rd = '0;
    logic [31:0] in_alu = '0;
    logic [31:0] in_wd = '0;
    logic        in_rw = 1'b0;
    logic [1:0]  in_sel = '0;
    logic        in_mw = 1'b0;
    logic        in_mr = 1'b0;
    logic        stall;
    logic [4:0]  wb_rd;
    logic [31:0] wb_alu;
    logic [31:0] wb_rdata;
    logic        wb_rw;
    logic [1:0]  wb_sel;

    int checks = 0;
    int failures = 0;

    mem_wb_stage #(.DEPTH_WORDS(DEPTH), .ADDR_W(ADDR_W), .MEM_LATENCY(LAT)) dut (
        .clk                  (clk),
        .reset                (reset),
        .Mem_In_Rd            (in_rd),
        .Mem_In_Aluresult     (in_alu),
        .Mem_In_ReadData2     (in_wd),
        .Mem_In_Reg_Write     (in_rw),
        .Mem_In_Output_Select (in_sel),
        .Mem_In_MemWrite      (in_mw),
        .Mem_In_MemRead       (in_mr),
        .Mem_Stall            (stall),
        .Wb_Out_Rd            (wb_rd),
        .Wb_Out_Aluresult     (wb_alu),
        .Wb_Out_ReadData      (wb_rdata),
        .Wb_Out_Reg_Write     (wb_rw),
        .Wb_Out_Output_Select (wb_sel)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // An access simply occupies LAT cycles; m_age counts cycles it has used.
    logic [31:0] m_mem [int];
    int          m_age = 0;
    bit          m_valid = 0;
    bit          e_rdata_known = 1;
    logic [4:0]  e_rd;
    logic [31:0] e_alu;
    logic [31:0] e_rdata;
    logic        e_rw;
    logic [1:0]  e_sel;

    // Model advance on each active edge.
    always @(posedge clk) begin
        int idx;
        idx = int'((in_alu >> 2) % DEPTH);
        if (reset) begin
            {e_rd, e_alu, e_rdata, e_rw, e_sel} = '0;
            e_rdata_known = 1;
            m_age   = 0;
            m_valid = 1;
        end else if (in_mr || in_mw) begin
            m_age++;
            if (m_age >= LAT) begin
                e_rd = in_rd; e_alu = in_alu; e_rw = in_rw; e_sel = in_sel;
                e_rdata = 32'd0;
                e_rdata_known = 1;
                if (in_mw) begin
                    m_mem[idx] = in_wd;
                end else if (m_mem.exists(idx)) begin
                    e_rdata = m_mem[idx];
                end else begin
                    e_rdata_known = 0;
                end
                m_age = 0;
            end else begin
                {e_rd, e_alu, e_rdata, e_rw, e_sel} = '0;
                e_rdata_known = 1;
            end
        end else begin
            e_rd = in_rd; e_alu = in_alu; e_rw = in_rw; e_sel = in_sel;
            e_rdata = 32'd0;
            e_rdata_known = 1;
        end
    end

    // Per-cycle compare against the model, away from the active edge.
    always @(negedge clk) begin
        logic exp_stall;
        if (m_valid) begin
            exp_stall = !reset && (in_mr || in_mw) && (m_age + 1 < LAT);
            chk("stall", 32'(stall), 32'(exp_stall));
            chk("wb_rd", 32'(wb_rd), 32'(e_rd));
            chk("wb_alu", wb_alu, e_alu);
            chk("wb_rw", 32'(wb_rw), 32'(e_rw));
            chk("wb_sel", 32'(wb_sel), 32'(e_sel));
            if (e_rdata_known) chk("wb_rdata", wb_rdata, e_rdata);
        end
    end

    // ---------------- stimulus ----------------
    logic s [8];

    task automatic set_in(input logic [4:0] rd, input logic [31:0] alu, input logic [31:0] wd,
                          input logic rw, input logic [1:0] sel, input logic mw, input logic mr);
        in_rd = rd; in_alu = alu; in_wd = wd; in_rw = rw; in_sel = sel; in_mw = mw; in_mr = mr;
    endtask

    // Hold one instruction for n cycles; returns 1 time unit after the last edge.
    task automatic op(input logic [4:0] rd, input logic [31:0] alu, input logic [31:0] wd,
                      input logic rw, input logic [1:0] sel, input logic mw, input logic mr,
                      input int n);
        set_in(rd, alu, wd, rw, sel, mw, mr);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            s[i] = stall;
            @(posedge clk);
        end
        #1;
    endtask

    initial begin
        // Reset held for two cycles with a store pending.
        set_in(5'd1, 32'h10, 32'hBAD, 1'b1, 2'd1, 1'b1, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rd", 32'(wb_rd), 32'd0);
        chk("rst_alu", wb_alu, 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        reset = 1'b0;

        op(5'd5, 32'h1234, 32'd0, 1'b1, 2'b01, 1'b0, 1'b0, 1);
        chk("pass_rd", 32'(wb_rd), 32'd5);
        chk("pass_alu", wb_alu, 32'h1234);
        chk("pass_rw", 32'(wb_rw), 32'd1);
        chk("pass_sel", 32'(wb_sel), 32'd1);
        chk("pass_rdata", wb_rdata, 32'd0);
        chk("pass_stall", 32'(s[0]), 32'd0);

        op(5'd7, 32'h10, 32'hDEADBEEF, 1'b0, 2'd0, 1'b1, 1'b0, LAT);
        chk("st_stall0", 32'(s[0]), 32'd1);
        chk("st_stall1", 32'(s[1]), 32'd1);
        chk("st_stall2", 32'(s[2]), 32'd0);

        op(5'd3, 32'h10, 32'd0, 1'b1, 2'b10, 1'b0, 1'b1, LAT);
        chk("ld_rdata", wb_rdata, 32'hDEADBEEF);
        chk("ld_rd", 32'(wb_rd), 32'd3);

        op(5'd0, 32'h400, 32'hA5A5A5A5, 1'b0, 2'd0, 1'b1, 1'b0, LAT);
        op(5'd4, 32'h000, 32'd0, 1'b1, 2'b10, 1'b0, 1'b1, LAT);
        chk("wrap_rdata", wb_rdata, 32'hA5A5A5A5);
        op(5'd4, 32'h402, 32'd0, 1'b1, 2'b10, 1'b0, 1'b1, LAT);
        chk("misal_rdata", wb_rdata, 32'hA5A5A5A5);

        // Reset in the second stall cycle of a store drops the write.
        op(5'd0, 32'h20, 32'h55, 1'b0, 2'd0, 1'b1, 1'b0, LAT);
        set_in(5'd0, 32'h20, 32'h11, 1'b0, 2'd0, 1'b1, 1'b0);
        @(negedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        op(5'd6, 32'h20, 32'd0, 1'b1, 2'b10, 1'b0, 1'b1, LAT);
        chk("rstmid_rdata", wb_rdata, 32'h55);

        op(5'd9, 32'h8, 32'h77, 1'b1, 2'b10, 1'b1, 1'b1, LAT);
        chk("rw_rdata", wb_rdata, 32'd0);
        op(5'd9, 32'h8, 32'd0, 1'b1, 2'b10, 1'b0, 1'b1, LAT);
        chk("rw_load", wb_rdata, 32'h77);

        // Reset with a store pending must not write the RAM.
        reset = 1'b1;
        set_in(5'd1, 32'h10, 32'hBAD, 1'b1, 2'd1, 1'b1, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        op(5'd2, 32'h10, 32'd0, 1'b1, 2'b10, 1'b0, 1'b1, LAT);
        chk("rst_nowrite", wb_rdata, 32'hDEADBEEF);

        op(5'd31, 32'hFFFF_FFFF, 32'd0, 1'b1, 2'b11, 1'b0, 1'b0, 1);
        chk("pass2_alu", wb_alu, 32'hFFFF_FFFF);
        op(5'd0, 32'd0, 32'd0, 1'b0, 2'd0, 1'b0, 1'b0, 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
